// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath select, strobe and ALU operation from the current state.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic       IllegalOp,
   output logic       InstrDone,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_RTEX   = 4'd7,
      S_RTWB   = 4'd8,  S_BEQEX = 4'd9,  S_IMMEX  = 4'd10, S_IMMWB  = 4'd11,
      S_JUMP   = 4'd12, S_JAL   = 4'd13, S_JR     = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                          OP_BEQ   = 6'b000100, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                          OP_J     = 6'b000010, OP_JAL  = 6'b000011;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                          FN_OR  = 6'b100101, FN_SLT = 6'b101010, FN_JR  = 6'b001000;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                          ALU_OR  = 3'b011, ALU_SLT = 3'b100;

   state_t r_state;
   state_t w_next;
   state_t w_dec_next;
   logic   r_run;
   logic   w_illegal;
   logic [2:0] w_rt_op;

   // MemReady is a completion qualifier, not a request/grant pair: the strobe for an access is held
   // steady in FETCH/MEMRD/MEMWR and the access completes in the first cycle MemReady is sampled high.

   always_comb begin
      w_dec_next = S_FETCH;
      w_illegal  = 1'b0;
      case (Opcode)
         OP_LW, OP_SW:     w_dec_next = S_MEMADR;
         OP_BEQ:           w_dec_next = S_BEQEX;
         OP_ADDI, OP_SLTI: w_dec_next = S_IMMEX;
         OP_J:             w_dec_next = S_JUMP;
         OP_JAL:           w_dec_next = S_JAL;
         OP_RTYPE: begin
            case (Funct)
               FN_JR:                                  w_dec_next = S_JR;
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  w_dec_next = S_RTEX;
               default:                                w_illegal  = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_rt_op = ALU_ADD;
      case (Funct)
         FN_SUB:  w_rt_op = ALU_SUB;
         FN_AND:  w_rt_op = ALU_AND;
         FN_OR:   w_rt_op = ALU_OR;
         FN_SLT:  w_rt_op = ALU_SLT;
         default: w_rt_op = ALU_ADD;
      endcase
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:   w_next = r_run ? S_FETCH : S_IDLE;
         S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: w_next = w_dec_next;
         S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = MemReady ? S_FETCH : S_MEMWR;
         S_RTEX:   w_next = S_RTWB;
         S_IMMEX:  w_next = S_IMMWB;
         S_MEMWB, S_RTWB, S_BEQEX, S_IMMWB, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
         default:  w_next = S_IDLE;
      endcase
   end

   // r_run holds IDLE for one extra cycle after reset release, so FETCH starts on the second edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
      end
   end

   assign State = r_state;

   always_comb begin
      PCEn      = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 2'b00;
      MemtoReg  = 2'b00;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      PCSrc     = 2'b00;
      ALUOp     = ALU_ADD;
      IllegalOp = 1'b0;
      InstrDone = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCEn    = MemReady;
         end
         S_DECODE: begin
            ALUSrcB   = 2'b11;
            IllegalOp = w_illegal;
            InstrDone = w_illegal;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg  = 2'b01;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_MEMWR: begin
            IorD      = 1'b1;
            MemWrite  = 1'b1;
            InstrDone = MemReady;
         end
         S_RTEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = w_rt_op;
         end
         S_RTWB: begin
            RegDst    = 2'b01;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA   = 1'b1;
            ALUOp     = ALU_SUB;
            PCSrc     = 2'b01;
            PCEn      = Zero;
            InstrDone = 1'b1;
         end
         S_IMMEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = (Opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
         end
         S_IMMWB: begin
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_JUMP: begin
            PCSrc     = 2'b10;
            PCEn      = 1'b1;
            InstrDone = 1'b1;
         end
         S_JAL: begin
            PCSrc     = 2'b10;
            PCEn      = 1'b1;
            RegDst    = 2'b10;
            MemtoReg  = 2'b10;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_JR: begin
            PCSrc     = 2'b11;
            PCEn      = 1'b1;
            InstrDone = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected per-cycle
// state/output sequence and replayed cycle by cycle against the controller.
module tb_multicycle_controller;

   logic       clk;
   logic       rst_n;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;
   logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, IllegalOp, InstrDone;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] State;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
      .InstrDone(InstrDone), .State(State)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // state numbers and instruction kinds
   localparam logic [3:0] IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5,
                          MEMWR = 6, RTEX = 7, RTWB = 8, BEQEX = 9, IMMEX = 10, IMMWB = 11,
                          JUMP = 12, JAL = 13, JR = 14;
   localparam int K_LW = 0, K_SW = 1, K_ADD = 2, K_SUB = 3, K_AND = 4, K_OR = 5, K_SLT = 6,
                  K_BEQ = 7, K_ADDI = 8, K_SLTI = 9, K_J = 10, K_JAL = 11, K_JR = 12,
                  K_BADOP = 13, K_BADFN = 14;

   logic [5:0] bad_ops[6] = '{6'b111111, 6'b000001, 6'b100000, 6'b001100, 6'b001101, 6'b000101};
   logic [5:0] bad_fns[5] = '{6'b000000, 6'b100001, 6'b000010, 6'b011000, 6'b111111};
   logic [5:0] rt_fns[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   wire [19:0] dut_outs = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                           ALUSrcA, ALUSrcB, PCSrc, ALUOp, IllegalOp, InstrDone};

   // scoreboard: {opcode, funct, state, memready, zero, outputs}
   logic [37:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [19:0] o(input logic pcen, input logic iord, input logic mrd,
                                     input logic mwr, input logic irw, input logic [1:0] rdst,
                                     input logic [1:0] m2r, input logic regw, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] pcsrc,
                                     input logic [2:0] aluop, input logic ill, input logic done);
      return {pcen, iord, mrd, mwr, irw, rdst, m2r, regw, srca, srcb, pcsrc, aluop, ill, done};
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] st,
                       input logic mr, input logic z, input logic [19:0] outs);
      exp_q.push_back({op, fn, st, mr, z, outs});
   endtask

   // Expand one instruction into the cycles it must take: wf fetch waits, wm memory waits.
   task automatic plan(input int kind, input int wf, input int wm, input logic z, input int sel);
      logic [5:0] op, fn;
      logic [2:0] rop;
      fn  = 6'($urandom_range(0, 63));
      rop = 3'b000;
      case (kind)
         K_LW:    op = 6'b100011;
         K_SW:    op = 6'b101011;
         K_BEQ:   op = 6'b000100;
         K_ADDI:  op = 6'b001000;
         K_SLTI:  op = 6'b001010;
         K_J:     op = 6'b000010;
         K_JAL:   op = 6'b000011;
         K_JR:    begin op = 6'b000000; fn = 6'b001000; end
         K_BADOP: op = bad_ops[sel];
         K_BADFN: begin op = 6'b000000; fn = bad_fns[sel]; end
         default: begin op = 6'b000000; fn = rt_fns[kind - K_ADD]; rop = 3'(kind - K_ADD); end
      endcase
      for (int i = 0; i < wf; i++)
         push(op, fn, FETCH, 1'b0, rbit(), o(0,0,1,0,0, 2'b00,2'b00,0,0, 2'b01,2'b00,3'b000,0,0));
      push(op, fn, FETCH, 1'b1, rbit(), o(1,0,1,0,1, 2'b00,2'b00,0,0, 2'b01,2'b00,3'b000,0,0));
      if (kind == K_BADOP || kind == K_BADFN) begin
         push(op, fn, DECODE, rbit(), rbit(), o(0,0,0,0,0, 2'b00,2'b00,0,0, 2'b11,2'b00,3'b000,1,1));
         return;
      end
      push(op, fn, DECODE, rbit(), rbit(), o(0,0,0,0,0, 2'b00,2'b00,0,0, 2'b11,2'b00,3'b000,0,0));
      case (kind)
         K_LW, K_SW: begin
            push(op, fn, MEMADR, rbit(), rbit(), o(0,0,0,0,0, 2'b00,2'b00,0,1, 2'b10,2'b00,3'b000,0,0));
            if (kind == K_LW) begin
               for (int i = 0; i < wm; i++)
                  push(op, fn, MEMRD, 1'b0, rbit(), o(0,1,1,0,0, 2'b00,2'b00,0,0, 2'b00,2'b00,3'b000,0,0));
               push(op, fn, MEMRD, 1'b1, rbit(), o(0,1,1,0,0, 2'b00,2'b00,0,0, 2'b00,2'b00,3'b000,0,0));
               push(op, fn, MEMWB, rbit(), rbit(), o(0,0,0,0,0, 2'b00,2'b01,1,0, 2'b00,2'b00,3'b000,0,1));
            end else begin
               for (int i = 0; i < wm; i++)
                  push(op, fn, MEMWR, 1'b0, rbit(), o(0,1,0,1,0, 2'b00,2'b00,0,0, 2'b00,2'b00,3'b000,0,0));
               push(op, fn, MEMWR, 1'b1, rbit(), o(0,1,0,1,0, 2'b00,2'b00,0,0, 2'b00,2'b00,3'b000,0,1));
            end
         end
         K_BEQ:
            push(op, fn, BEQEX, rbit(), z, o(z,0,0,0,0, 2'b00,2'b00,0,1, 2'b00,2'b01,3'b001,0,1));
         K_ADDI, K_SLTI: begin
            push(op, fn, IMMEX, rbit(), rbit(),
                 o(0,0,0,0,0, 2'b00,2'b00,0,1, 2'b10,2'b00, (kind == K_SLTI) ? 3'b100 : 3'b000, 0,0));
            push(op, fn, IMMWB, rbit(), rbit(), o(0,0,0,0,0, 2'b00,2'b00,1,0, 2'b00,2'b00,3'b000,0,1));
         end
         K_J:   push(op, fn, JUMP, rbit(), rbit(), o(1,0,0,0,0, 2'b00,2'b00,0,0, 2'b00,2'b10,3'b000,0,1));
         K_JAL: push(op, fn, JAL, rbit(), rbit(), o(1,0,0,0,0, 2'b10,2'b10,1,0, 2'b00,2'b10,3'b000,0,1));
         K_JR:  push(op, fn, JR, rbit(), rbit(), o(1,0,0,0,0, 2'b00,2'b00,0,0, 2'b00,2'b11,3'b000,0,1));
         default: begin
            push(op, fn, RTEX, rbit(), rbit(), o(0,0,0,0,0, 2'b00,2'b00,0,1, 2'b00,2'b00,rop,0,0));
            push(op, fn, RTWB, rbit(), rbit(), o(0,0,0,0,0, 2'b01,2'b00,1,0, 2'b00,2'b00,3'b000,0,1));
         end
      endcase
   endtask

   task automatic push_idle();
      push(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), IDLE, rbit(), rbit(), 20'd0);
   endtask

   // driver: one queued cycle per clock; optionally reset in the first MEMRD wait cycle
   task automatic run_steps(input bit reset_in_memrd);
      logic [37:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         Opcode   = e[37:32];
         Funct    = e[31:26];
         MemReady = e[21];
         Zero     = e[20];
         #1;
         check("state", 32'(State), 32'(e[25:22]));
         check("outputs", 32'(dut_outs), 32'(e[19:0]));
         if (reset_in_memrd && e[25:22] == MEMRD && !e[21]) begin
            #2;
            MemReady = 1'b1;
            Zero     = 1'b1;
            rst_n    = 1'b0;
            #1;
            check("reset_mid_state", 32'(State), 32'(IDLE));
            check("reset_mid_outputs", 32'(dut_outs), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            return;
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      Opcode   = 6'd0;
      Funct    = 6'd0;
      Zero     = 1'b1;
      MemReady = 1'b1;
      #3;
      check("reset_state", 32'(State), 32'(IDLE));
      check("reset_outputs", 32'(dut_outs), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      push_idle();
      plan(K_BADOP, 0, 0, 1'b0, 0);
      plan(K_BADFN, 0, 0, 1'b0, 0);
      plan(K_ADD, 0, 0, 1'b0, 0);
      plan(K_LW, 2, 3, 1'b0, 0);
      plan(K_BEQ, 0, 0, 1'b1, 0);
      plan(K_BEQ, 0, 0, 1'b0, 0);
      plan(K_JAL, 0, 0, 1'b0, 0);
      plan(K_JR, 0, 0, 1'b0, 0);
      plan(K_SW, 1, 2, 1'b0, 0);
      run_steps(1'b0);

      plan(K_LW, 1, 3, 1'b0, 0);
      run_steps(1'b1);

      push_idle();
      for (int n = 0; n < 250; n++)
         plan($urandom_range(0, 14), $urandom_range(0, 2), $urandom_range(0, 3), rbit(),
              $urandom_range(0, 4));
      run_steps(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller
Moore-style control FSM for the multi-cycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives every datapath mux select, write enable and ALU operation. It stalls on a memory-ready handshake. The 2:1, 3:1 and 4:1 select muxes consume its select outputs directly.
## Interface
- Parameters: none.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26]; stable from the end of FETCH until the next FETCH.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, same cycle.
- MemReady  in  1  memory access completes this cycle.
- PCEn  out  1  PC register write enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- RegDst  out  2  write-register select: 00 = rt, 01 = rd, 10 = 5'd31.
- MemtoReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 32'd4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode/funct.
- InstrDone  out  1  one-cycle pulse in an instruction's final state.
- State  out  4  current state, for debug.
## Operation
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTEX 7, RTWB 8, BEQEX 9, IMMEX 10, IMMWB 11, JUMP 12, JAL 13, JR 14. Code 15 goes to IDLE.
- All outputs are decoded from State, plus Zero/MemReady/Opcode/Funct where noted. Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=add.
  - IRWrite = PCEn = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 → MEMADR; 000100 → BEQEX; 001000/001010 → IMMEX; 000010 → JUMP; 000011 → JAL.
  - 000000 with funct 001000 → JR; funct 100000/100010/100100/100101/101010 → RTEX.
  - Anything else: IllegalOp=1, InstrDone=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Holds until MemReady, then MEMWB.
- MEMWB: RegDst=00, MemtoReg=01, RegWrite=1, InstrDone=1.
- MEMWR: IorD=1, MemWrite=1. Holds until MemReady; InstrDone=MemReady; then FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00. ALUOp from funct: add, sub, and, or, slt respectively.
- RTWB: RegDst=01, MemtoReg=00, RegWrite=1, InstrDone=1.
- BEQEX: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCEn=Zero, InstrDone=1.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp = add for addi, slt for slti.
- IMMWB: RegDst=00, MemtoReg=00, RegWrite=1, InstrDone=1.
- JUMP: PCSrc=10, PCEn=1, InstrDone=1.
- JAL: PCSrc=10, PCEn=1, RegDst=10, MemtoReg=10, RegWrite=1, InstrDone=1. Writes the already-incremented PC+4.
- JR: PCSrc=11, PCEn=1, InstrDone=1.
- The states after MEMWB, RTWB, BEQEX, IMMWB, JUMP, JAL and JR return to FETCH.
## Timing
- Reset: asynchronous assert forces State=IDLE and all outputs 0, including mid-instruction and during a memory wait.
- The first FETCH is the second rising edge after rst_n deasserts.
- Latency with zero-wait memory (MemReady tied 1):
  - lw 5 cycles; R-type, sw, addi, slti 4; beq, j, jal, jr 3.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- During a wait, strobes and selects stay stable; IRWrite and PCEn stay 0.
- Outputs are valid combinationally within the cycle; there are no registered outputs.
- Zero and MemReady have a combinational path to PCEn, IRWrite and InstrDone only.
## Test plan
- Reset mid-MEMRD: assert rst_n=0 → State=0 and every output 0 immediately. Release → IDLE, then FETCH with MemRead=1.
- add $3,$1,$2, MemReady=1: States 1,2,7,8. RTWB shows RegDst=01, RegWrite=1, InstrDone=1. Next state FETCH.
- lw with MemReady low for 2 cycles in FETCH and 3 in MEMRD: 10 total cycles. IRWrite pulses exactly once; RegWrite occurs only in MEMWB with MemtoReg=01.
- beq: with Zero=1, PCEn=1 and PCSrc=01 in BEQEX. With Zero=0, PCEn=0. Both complete in 3 cycles.
- jal: JAL state shows PCEn=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1. jr (funct 001000) gives PCSrc=11.
- Opcode 111111, then R-type funct 000000: IllegalOp plus InstrDone in DECODE, RegWrite, MemWrite and PCEn never asserted, next state FETCH.
